ram2048x8_ctrl: RTL

Request-driven access controller sitting directly upstream of the 2048x8 banked RAM. Accepts single read/write requests on a valid/ready interface, sequences the RAM's address, active-low chip-select, read/write strobe and bidirectional data bus, and returns one response per request. Flags accesses to the unmapped top quarter of the address space without touching the RAM. Optionally provides a hardware clear engine that zero-fills the mapped range.

---
 rtl/ram2048x8_ctrl_if.sv | 25 ++
 rtl/ram2048x8_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ram2048x8_ctrl_if.sv
// Request/response handshake bundle for ram2048x8_ctrl.
// The master issues requests; the controller (slave) returns responses.
interface ram2048x8_ctrl_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram2048x8_ctrl.sv
// Valid/ready access controller for the 2048x8 banked RAM.
// Define RAMCTRL_CLEAR_EN to add the zero-fill clear engine.
module ram2048x8_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 1,
  parameter int MAP_TOP = 1536
) (
  input  logic              clk,
  input  logic              rst_n,
  ram2048x8_ctrl_if.slave   bus,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_rw,
  output logic              mem_cs
`ifdef RAMCTRL_CLEAR_EN
  ,
  input  logic              clear_start,
  output logic              clear_busy
`endif
);

  localparam logic [ADDR_W:0]   TOP_V  = (ADDR_W+1)'(MAP_TOP);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(MAP_TOP - 1);
  localparam logic [2:0]        RDW    = 3'(RD_WAIT);

`ifdef RAMCTRL_CLEAR_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_DONE, S_CLR_SETUP, S_CLR_ACCESS
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_DONE
  } state_t;
`endif

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              cs_q, cs_d;
  logic              drive_q, drive_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              clr_go;

`ifdef RAMCTRL_CLEAR_EN
  assign clr_go     = clear_start;
  assign clear_busy = busy_q;
`else
  assign clr_go     = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    cs_d        = 1'b1;
    drive_d     = drive_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (clr_go) begin
`ifdef RAMCTRL_CLEAR_EN
          state_d = S_CLR_SETUP;
`endif
          ready_d = 1'b0;
          busy_d  = 1'b1;
          addr_d  = '0;
          rw_d    = 1'b0;
          drive_d = 1'b1;
          wdata_d = '0;
        end else if (bus.req_valid) begin
          ready_d = 1'b0;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          if ({1'b0, bus.req_addr} >= TOP_V) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
            rdata_d     = '0;
          end else begin
            state_d = S_SETUP;
            addr_d  = bus.req_addr;
            rw_d    = ~bus.req_we;
            drive_d = bus.req_we;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cs_d    = 1'b0;
        cnt_d   = '0;
      end
      S_ACCESS: begin
        if (we_q || cnt_q == RDW) begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          err_d       = 1'b0;
          rdata_d     = we_q ? '0 : mem_data;
        end else begin
          cs_d  = 1'b0;
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        rw_d    = 1'b1;
        drive_d = 1'b0;
      end
`ifdef RAMCTRL_CLEAR_EN
      S_CLR_SETUP: begin
        state_d = S_CLR_ACCESS;
        cs_d    = 1'b0;
      end
      S_CLR_ACCESS: begin
        if (addr_q == LAST_A) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          rw_d    = 1'b1;
          drive_d = 1'b0;
        end else begin
          state_d = S_CLR_SETUP;
          addr_d  = addr_q + ADDR_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset releases the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      rw_q        <= 1'b1;
      cs_q        <= 1'b1;
      drive_q     <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      cs_q        <= cs_d;
      drive_q     <= drive_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign mem_addr      = addr_q;
  assign mem_rw        = rw_q;
  assign mem_cs        = cs_q;
  assign mem_data      = drive_q ? wdata_q : {DATA_W{1'bz}};

endmodule
